ext_seq_ctrl: RTL

- Multi-cycle sequencer that drives the shared 16-to-32 immediate extender (EOp encoding: 00 sign, 01 zero, 10 high-half, 11 sign then shift left by 2).
- Accepts one MIPS instruction word at a time over a valid/ready handshake and decodes the opcode into an EOp.
- Drives the extender with the immediate and EOp, captures its 32-bit result, computes a branch target for beq, and presents the result over a second valid/ready handshake.
- Sits between fetch and the ALU operand mux in the multi-cycle CPU.

---
 rtl/ext_seq_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ext_seq_ctrl.sv
// ext_seq_ctrl: multi-cycle sequencer for the shared 16-to-32 immediate
// extender. It accepts one instruction, decodes the opcode into an EOp,
// drives the extender, captures the extended value and the beq branch target,
// and then presents the result on an output valid/ready handshake.
module ext_seq_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  output logic [15:0]        ext_imm,
  output logic [1:0]         ext_eop,
  input  logic [31:0]        ext_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_value,
  output logic [1:0]         out_eop,
  output logic [31:0]        out_target,
  output logic               out_illegal,
  output logic [COUNT_W-1:0] count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXT    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_HIGH = 2'b10;
  localparam logic [1:0] EOP_SSH2 = 2'b11;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [5:0]  op_q;
  logic [15:0] imm_q;
  logic [31:0] pc_q;
  logic        illegal_q;
  logic        beq_q;

  logic [1:0]  dec_eop;
  logic        dec_illegal;
  logic        dec_beq;

  // The rs/rt fields play no part in immediate extension.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^in_instr[25:16];

  // Handshake flags follow directly from the current state.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Opcode decode into extender operation; unknown opcodes flag illegal.
  always_comb begin
    dec_eop     = EOP_SIGN;
    dec_illegal = 1'b0;
    dec_beq     = 1'b0;
    case (op_q)
      OP_ADDIU, OP_LW, OP_SW: dec_eop = EOP_SIGN;
      OP_ORI:                 dec_eop = EOP_ZERO;
      OP_LUI:                 dec_eop = EOP_HIGH;
      OP_BEQ: begin
        dec_eop = EOP_SSH2;
        dec_beq = 1'b1;
      end
      default: begin
        dec_eop     = EOP_SIGN;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Sequencer: accept, decode, extend/capture, then hold until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      illegal_q   <= 1'b0;
      beq_q       <= 1'b0;
      ext_imm     <= '0;
      ext_eop     <= EOP_SIGN;
      out_value   <= '0;
      out_eop     <= EOP_SIGN;
      out_target  <= '0;
      out_illegal <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= in_instr[31:26];
            imm_q <= in_instr[15:0];
            pc_q  <= in_pc;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          ext_imm   <= imm_q;
          ext_eop   <= dec_eop;
          illegal_q <= dec_illegal;
          beq_q     <= dec_beq;
          state     <= S_EXT;
        end
        S_EXT: begin
          out_value   <= ext_result;
          out_eop     <= ext_eop;
          out_illegal <= illegal_q;
          out_target  <= beq_q ? (pc_q + 32'd4 + ext_result) : '0;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            count <= count + COUNT_ONE;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
